// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register. Instruction memory is combinational, so the word
// addressed by the current PC is captured into IF/ID on the next edge.
//
// state  | meaning
// -------+-----------------------------------------------------------
// BOOT   | single cycle after reset release; pc held, IF/ID bubble
// RUN    | normal fetch with stall / flush / redirect handling
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'b00000100000000000000000000000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        align_err
);

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        align_err_q, align_err_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  // Next-state, next-PC and IF/ID selection; jump outranks branch, and any
  // redirect outranks stall and flush.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_plus4_d    = pc_plus4_q;
    valid_d       = valid_q;
    fetch_count_d = fetch_count_q;
    align_err_d   = align_err_q;

    redirect = jump | branch_taken;
    target   = jump ? jump_target : branch_target;
    pc_inc   = pc_q + 32'd4;

    unique case (state_q)
      S_BOOT: begin
        state_d    = S_RUN;
        instr_d    = NOP;
        pc_plus4_d = 32'd0;
        valid_d    = 1'b0;
      end
      S_RUN: begin
        if (redirect) begin
          pc_d       = {target[31:2], 2'b00};
          instr_d    = NOP;
          pc_plus4_d = 32'd0;
          valid_d    = 1'b0;
          if (target[1:0] != 2'b00) align_err_d = 1'b1;
        end else if (stall) begin
          // pc and IF/ID hold unless the stalled slot is also squashed
          if (flush) begin
            instr_d    = NOP;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
          end
        end else if (flush) begin
          pc_d       = pc_inc;
          instr_d    = NOP;
          pc_plus4_d = 32'd0;
          valid_d    = 1'b0;
        end else begin
          pc_d          = pc_inc;
          instr_d       = imem_data;
          pc_plus4_d    = pc_inc;
          valid_d       = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State, PC and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      pc_plus4_q    <= 32'd0;
      valid_q       <= 1'b0;
      fetch_count_q <= 32'd0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_plus4_q    <= pc_plus4_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
      align_err_q   <= align_err_d;
    end
  end

  assign imem_address      = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc_plus4    = pc_plus4_q;
  assign if_id_valid       = valid_q;
  assign fetch_count       = fetch_count_q;
  assign align_err         = align_err_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios followed by random
// hazard traffic, all compared against a cycle-level reference model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0400_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_address, imem_data;
  logic [31:0] if_id_instruction, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, align_err;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid, m_align, m_boot;

  instruction_fetch_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .flush             (flush),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump              (jump),
    .jump_target       (jump_target),
    .imem_address      (imem_address),
    .imem_data         (imem_data),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .fetch_count       (fetch_count),
    .align_err         (align_err)
  );

  always #5 clk = ~clk;

  // memory contents: a scrambled function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_data = mem_word(imem_address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    imem_address,             m_pc);
    check({tag, ".instr"}, if_id_instruction,        m_instr);
    check({tag, ".pp4"},   if_id_pc_plus4,           m_pp4);
    check({tag, ".valid"}, {31'd0, if_id_valid},     {31'd0, m_valid});
    check({tag, ".count"}, fetch_count,              m_cnt);
    check({tag, ".align"}, {31'd0, align_err},       {31'd0, m_align});
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP; m_pp4 = 0; m_valid = 0;
    m_cnt = 0; m_align = 0; m_boot = 1;
  endtask

  task automatic bubble();
    m_instr = NOP; m_pp4 = 0; m_valid = 0;
  endtask

  // one clock edge of the fetch stage, expressed from the rules
  task automatic model_edge(input bit st, input bit fl, input bit br,
                            input logic [31:0] bt, input bit jp, input logic [31:0] jt);
    logic [31:0] tgt;
    if (m_boot) begin
      m_boot = 0;
      bubble();
    end else if (jp || br) begin
      tgt = jp ? jt : bt;
      if (tgt % 4 != 0) m_align = 1;
      m_pc = tgt - (tgt % 4);
      bubble();
    end else if (st) begin
      if (fl) bubble();
    end else if (fl) begin
      m_pc = m_pc + 4;
      bubble();
    end else begin
      m_instr = mem_word(m_pc);
      m_pp4   = m_pc + 4;
      m_valid = 1;
      m_cnt   = m_cnt + 1;
      m_pc    = m_pc + 4;
    end
  endtask

  // drive inputs (called at negedge), clock once, then compare
  task automatic step(input string tag, input bit st, input bit fl, input bit br,
                      input logic [31:0] bt, input bit jp, input logic [31:0] jt);
    stall = st; flush = fl; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt;
    @(posedge clk);
    model_edge(st, fl, br, bt, jp, jt);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 32'd0, 0, 32'd0);
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1;

    // BOOT bubble, then sequential fetch of W0, W1
    step("boot", 1, 1, 1, 32'h40, 1, 32'h80);
    idle("seq0");
    idle("seq1");
    // stall held two cycles at pc = 8
    step("stall0", 1, 0, 0, 32'd0, 0, 32'd0);
    step("stall1", 1, 0, 0, 32'd0, 0, 32'd0);
    idle("seq2");
    check("cnt3", fetch_count, 32'd3);
    // taken branch at pc = 12
    step("branch", 0, 0, 1, 32'h40, 0, 32'd0);
    idle("at40");
    check("pp4_44", if_id_pc_plus4, 32'h44);
    // jump beats branch and stall
    step("jmp_br_st", 1, 0, 1, 32'h40, 1, 32'h100);
    idle("at100");
    // flush alone, then stall with flush
    step("flush", 0, 1, 0, 32'd0, 0, 32'd0);
    idle("postflush");
    step("stallflush", 1, 1, 0, 32'd0, 0, 32'd0);
    // misaligned jump, then aligned redirects keep the sticky flag
    step("misjump", 0, 0, 0, 32'd0, 1, 32'h203);
    check("pc200", imem_address, 32'h200);
    step("alignbr", 0, 0, 1, 32'h300, 0, 32'd0);
    step("alignjp", 0, 0, 0, 32'd0, 1, 32'h400);
    // PC wrap at the top of the address space
    step("tojump", 0, 0, 0, 32'd0, 1, 32'hFFFF_FFFC);
    idle("wrap");
    check("wrap_pc", imem_address, 32'h0);

    // random hazard traffic
    for (int i = 0; i < 300; i++) begin
      bit st, fl, br, jp;
      logic [31:0] bt, jt;
      st = ($urandom_range(0, 99) < 20);
      fl = ($urandom_range(0, 99) < 15);
      br = ($urandom_range(0, 99) < 10);
      jp = ($urandom_range(0, 99) < 8);
      bt = {20'd0, $urandom_range(0, 4095)};
      jt = {20'd0, $urandom_range(0, 4095)};
      if ($urandom_range(0, 3) != 0) begin
        bt[1:0] = 2'b00;
        jt[1:0] = 2'b00;
      end
      step("rand", st, fl, br, bt, jp, jt);
    end

    // reset asserted mid-cycle clears outputs asynchronously
    idle("prereset");
    @(posedge clk);
    model_edge(0, 0, 0, 32'd0, 0, 32'd0);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    step("reboot", 0, 0, 0, 32'd0, 1, 32'h123);
    idle("after0");
    idle("after1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- PC register, next-PC selection and IF/ID pipeline register for the pipelined MIPS core.
- Drives the byte address into the combinational instruction memory and receives the 32-bit big-endian word back in the same cycle.
- Registers that word, with PC+4 and a valid bit, for the decode stage.
- Handles stall, flush and branch/jump redirect, and inserts the pipeline NOP encoding on bubbles.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP, 32'b00000100000000000000000000000000, instruction word injected on bubbles; same encoding as the instruction memory fill.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit hold request for PC and IF/ID.
- flush  input  1  squash the IF/ID contents.
- branch_taken  input  1  branch resolved taken in ID.
- branch_target  input  32  branch destination byte address.
- jump  input  1  jump decoded in ID.
- jump_target  input  32  jump destination byte address.
- imem_address  output  32  byte address to instruction memory; equals current PC.
- imem_data  input  32  instruction word from memory (combinational).
- if_id_instruction  output  32  registered instruction for ID.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  1 = real instruction; 0 = bubble.
- fetch_count  output  32  number of valid instructions registered into IF/ID.
- align_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - pc = RESET_PC, if_id_instruction = NOP, if_id_pc_plus4 = 0, if_id_valid = 0, fetch_count = 0, align_err = 0.
  - State goes to BOOT.
- imem_address = pc (combinational, no latency). The fetched word appears in IF/ID one clock later.
- State machine:
  - BOOT: lasts exactly one cycle after reset release. pc holds RESET_PC; IF/ID loads NOP with valid = 0. Next state is RUN unconditionally. Inputs are ignored in BOOT.
  - RUN: normal operation. Leaves RUN only on reset.
- Redirect selection in RUN, priority jump > branch_taken > sequential:
  - jump = 1: target = jump_target.
  - else branch_taken = 1: target = branch_target.
  - else: no redirect.
  - The selected target is loaded with bits [1:0] forced to 0.
  - If the original target bits [1:0] != 0, align_err sets to 1 and stays set until reset.
- Update rules in RUN, evaluated in this order:
  1. Redirect active: pc <= aligned target, IF/ID <= NOP with valid 0 and pc_plus4 0. Redirect overrides stall and flush.
  2. Else stall = 1: pc holds; IF/ID holds, unless flush = 1, in which case IF/ID <= NOP, valid 0.
  3. Else flush = 1: pc <= pc + 4; IF/ID <= NOP, valid 0.
  4. Else: pc <= pc + 4; if_id_instruction <= imem_data, if_id_pc_plus4 <= pc + 4, if_id_valid <= 1.
- Arithmetic:
  - pc + 4 is modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
  - fetch_count increments by 1 only on a cycle taking rule 4, and wraps from 32'hFFFFFFFF to 0.
- Simultaneous events:
  - jump with branch_taken: jump wins and branch_target is ignored.
  - Redirect with stall: redirect is taken and the stall is dropped for that cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). The BOOT cycle repeats after release.
- No X propagation: imem_data is sampled only under rule 4.

Test Plan:
- Reset then free run with memory words W0..W3 at 0,4,8,12 → BOOT cycle gives valid = 0 and NOP. Next edges give (W0, 4), (W1, 8), (W2, 12) with valid = 1; fetch_count = 3.
- Stall held 2 cycles at pc = 8 → imem_address stays 8 and IF/ID holds (W1, 8). On release, W2 is registered and fetch_count does not count the stall cycles.
- branch_taken = 1, target 32'h40, at pc = 12 → next pc = 32'h40, IF/ID = NOP with valid = 0. The following cycle registers the word at 32'h40 with pc_plus4 = 32'h44.
- jump = 1 (target 32'h100) with branch_taken = 1 (target 32'h40) and stall = 1 → pc = 32'h100; bubble is inserted and the stall is ignored.
- Misaligned jump_target 32'h00000203 → pc = 32'h200, align_err = 1, and it remains 1 after later aligned redirects.
- pc = 32'hFFFFFFFC, no hazards → next pc = 0 and if_id_pc_plus4 = 0. A reset asserted mid-cycle immediately clears valid and fetch_count and forces pc to RESET_PC.
